// File: rtl/mult_pipe_pkg.sv
// Shared encodings, widths and the per-stage record for the pipelined multiplier.
package mult_pipe_pkg;

    localparam int XLEN           = 64;
    localparam int FU_SEL_W       = 3;
    localparam int PRF_IDX_W      = 6;
    localparam int ROB_IDX_W      = 5;
    localparam int BR_MASK_W      = 4;
    localparam int EX_CYCLES_MULT = 4;

    localparam logic [FU_SEL_W-1:0] FU_SEL_ALU  = 3'd0;
    localparam logic [FU_SEL_W-1:0] FU_SEL_MULT = 3'd1;
    localparam logic [FU_SEL_W-1:0] FU_SEL_LSU  = 3'd2;
    localparam logic [FU_SEL_W-1:0] FU_SEL_BR   = 3'd3;

    // Datapath fields are XLEN wide; narrower DATA_W configurations use the low bits.
    typedef struct packed {
        logic                 vld;
        logic [XLEN-1:0]      prod;
        logic [XLEN-1:0]      mcand;
        logic [XLEN-1:0]      mplier;
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } mult_stage_t;

endpackage

// File: rtl/mult_stage.sv
// One radix-2^CHUNK_W step: accumulate a partial product, then apply branch
// mask clearing or mispredict squash to the operation passing through.
module mult_stage
    import mult_pipe_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16
) (
    input  mult_stage_t          st_i,
    input  logic                 br_pred_correct,
    input  logic                 br_recovery,
    input  logic [BR_MASK_W-1:0] br_tag_fix,
    output mult_stage_t          st_o
);

    always_comb begin
        st_o = st_i;
        st_o.prod[DATA_W-1:0]   = st_i.prod[DATA_W-1:0]
                                + st_i.mcand[DATA_W-1:0] * DATA_W'(st_i.mplier[CHUNK_W-1:0]);
        st_o.mcand[DATA_W-1:0]  = st_i.mcand[DATA_W-1:0] << CHUNK_W;
        st_o.mplier[DATA_W-1:0] = st_i.mplier[DATA_W-1:0] >> CHUNK_W;
        // Recovery wins over a same-cycle correct prediction.
        if (br_recovery) begin
            if ((st_i.br_mask & br_tag_fix) != '0) begin
                st_o.vld = 1'b0;
            end
        end else if (br_pred_correct) begin
            st_o.br_mask = st_i.br_mask & ~br_tag_fix;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Fixed-latency pipelined multiplier with branch-mask tracking and squash.
// No back-pressure: the issue scheduler reserves the completion slot.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int STAGES = EX_CYCLES_MULT,
    parameter int DATA_W = XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_vld_i,
    input  logic [FU_SEL_W-1:0]  iss_fu_sel_i,
    input  logic [DATA_W-1:0]    iss_opa_i,
    input  logic [DATA_W-1:0]    iss_opb_i,
    input  logic [PRF_IDX_W-1:0] iss_dest_tag_i,
    input  logic [ROB_IDX_W-1:0] iss_rob_idx_i,
    input  logic [BR_MASK_W-1:0] iss_br_mask_i,
    input  logic                 rob_br_pred_correct_i,
    input  logic                 rob_br_recovery_i,
    input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
    output logic                 mult_done_o,
    output logic [DATA_W-1:0]    mult_result_o,
    output logic [PRF_IDX_W-1:0] mult_dest_tag_o,
    output logic [ROB_IDX_W-1:0] mult_rob_idx_o,
    output logic [BR_MASK_W-1:0] mult_br_mask_o
);

    localparam int CHUNK_W = DATA_W / STAGES;

    mult_stage_t stage_in [STAGES];
    mult_stage_t stage_n  [STAGES];
    mult_stage_t stage_r  [STAGES];

    // Stage 0 sees the issuing operation; its squash doubles as "not accepted".
    always_comb begin
        stage_in[0] = '0;
        stage_in[0].vld                 = iss_vld_i && (iss_fu_sel_i == FU_SEL_MULT);
        stage_in[0].mcand[DATA_W-1:0]   = iss_opa_i;
        stage_in[0].mplier[DATA_W-1:0]  = iss_opb_i;
        stage_in[0].dest_tag            = iss_dest_tag_i;
        stage_in[0].rob_idx             = iss_rob_idx_i;
        stage_in[0].br_mask             = iss_br_mask_i;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_r[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        mult_stage #(
            .DATA_W  (DATA_W),
            .CHUNK_W (CHUNK_W)
        ) u_stage (
            .st_i            (stage_in[g]),
            .br_pred_correct (rob_br_pred_correct_i),
            .br_recovery     (rob_br_recovery_i),
            .br_tag_fix      (rob_br_tag_fix_i),
            .st_o            (stage_n[g])
        );
    end

    // Whole records are cleared so every output reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= stage_n[k];
            end
        end
    end

    assign mult_done_o     = stage_r[STAGES-1].vld;
    assign mult_result_o   = stage_r[STAGES-1].prod[DATA_W-1:0];
    assign mult_dest_tag_o = stage_r[STAGES-1].dest_tag;
    assign mult_rob_idx_o  = stage_r[STAGES-1].rob_idx;
    assign mult_br_mask_o  = stage_r[STAGES-1].br_mask;

endmodule

// File: tb/tb_mult_pipe.sv
// Randomized and directed bench for mult_pipe against a queue-based model of in-flight ops.
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int STAGES = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 iss_vld_i;
    logic [FU_SEL_W-1:0]  iss_fu_sel_i;
    logic [63:0]          iss_opa_i, iss_opb_i;
    logic [PRF_IDX_W-1:0] iss_dest_tag_i;
    logic [ROB_IDX_W-1:0] iss_rob_idx_i;
    logic [BR_MASK_W-1:0] iss_br_mask_i;
    logic                 rob_br_pred_correct_i, rob_br_recovery_i;
    logic [BR_MASK_W-1:0] rob_br_tag_fix_i;
    logic                 mult_done_o;
    logic [63:0]          mult_result_o;
    logic [PRF_IDX_W-1:0] mult_dest_tag_o;
    logic [ROB_IDX_W-1:0] mult_rob_idx_o;
    logic [BR_MASK_W-1:0] mult_br_mask_o;

    mult_pipe #(.STAGES(STAGES), .DATA_W(64)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .iss_vld_i             (iss_vld_i),
        .iss_fu_sel_i          (iss_fu_sel_i),
        .iss_opa_i             (iss_opa_i),
        .iss_opb_i             (iss_opb_i),
        .iss_dest_tag_i        (iss_dest_tag_i),
        .iss_rob_idx_i         (iss_rob_idx_i),
        .iss_br_mask_i         (iss_br_mask_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_tag_fix_i      (rob_br_tag_fix_i),
        .mult_done_o           (mult_done_o),
        .mult_result_o         (mult_result_o),
        .mult_dest_tag_o       (mult_dest_tag_o),
        .mult_rob_idx_o        (mult_rob_idx_o),
        .mult_br_mask_o        (mult_br_mask_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]          res;
        logic [PRF_IDX_W-1:0] tag;
        logic [ROB_IDX_W-1:0] rob;
        logic [BR_MASK_W-1:0] mask;
        int                   age;
    } op_t;

    op_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit found = 0;
        op_t o;
        foreach (q[i]) begin
            if (q[i].age == STAGES) begin
                found = 1;
                o = q[i];
            end
        end
        chk("done", 64'(mult_done_o), 64'(found));
        if (mult_done_o) done_cnt++;
        if (found && mult_done_o) begin
            chk("result", mult_result_o, o.res);
            chk("dest_tag", 64'(mult_dest_tag_o), 64'(o.tag));
            chk("rob_idx", 64'(mult_rob_idx_o), 64'(o.rob));
            chk("br_mask", 64'(mult_br_mask_o), 64'(o.mask));
        end
    endtask

    // Advance one edge: the model reads the inputs the DUT sampled at that edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            op_t nq[$];
            bit  rec_only_pc;
            rec_only_pc = rob_br_pred_correct_i && !rob_br_recovery_i;
            foreach (q[i]) begin
                if (q[i].age < STAGES &&
                    !(rob_br_recovery_i && (q[i].mask & rob_br_tag_fix_i) != 0)) begin
                    op_t o;
                    o = q[i];
                    if (rec_only_pc) o.mask = o.mask & ~rob_br_tag_fix_i;
                    o.age = o.age + 1;
                    nq.push_back(o);
                end
            end
            if (iss_vld_i && iss_fu_sel_i == FU_SEL_MULT &&
                !(rob_br_recovery_i && (iss_br_mask_i & rob_br_tag_fix_i) != 0)) begin
                op_t n;
                n.res  = iss_opa_i * iss_opb_i;
                n.tag  = iss_dest_tag_i;
                n.rob  = iss_rob_idx_i;
                n.mask = rec_only_pc ? (iss_br_mask_i & ~rob_br_tag_fix_i) : iss_br_mask_i;
                n.age  = 1;
                nq.push_back(n);
            end
            q = nq;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic pc = 0, input logic rec = 0, input logic [3:0] fix = 0);
        iss_vld_i = 0;
        rob_br_pred_correct_i = pc;
        rob_br_recovery_i = rec;
        rob_br_tag_fix_i = fix;
        cycle();
        rob_br_pred_correct_i = 0;
        rob_br_recovery_i = 0;
        rob_br_tag_fix_i = 0;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input int tag,
                         input int rob, input logic [3:0] mask,
                         input logic [FU_SEL_W-1:0] fu = FU_SEL_MULT);
        iss_vld_i      = 1;
        iss_fu_sel_i   = fu;
        iss_opa_i      = a;
        iss_opb_i      = b;
        iss_dest_tag_i = PRF_IDX_W'(tag);
        iss_rob_idx_i  = ROB_IDX_W'(rob);
        iss_br_mask_i  = mask;
        cycle();
        iss_vld_i = 0;
    endtask

    initial begin
        int k;
        rst = 1;
        iss_vld_i = 0; iss_fu_sel_i = FU_SEL_ALU; iss_opa_i = 0; iss_opb_i = 0;
        iss_dest_tag_i = 0; iss_rob_idx_i = 0; iss_br_mask_i = 0;
        rob_br_pred_correct_i = 0; rob_br_recovery_i = 0; rob_br_tag_fix_i = 0;
        #2;
        chk("rst_done", 64'(mult_done_o), 64'd0);
        chk("rst_result", mult_result_o, 64'd0);
        chk("rst_tag", 64'(mult_dest_tag_o), 64'd0);
        cycle(); cycle();
        rst = 0;
        idle();

        // single op and latency
        issue(64'd7, 64'd6, 12, 3, 4'b0000);
        k = 1;
        while (!mult_done_o && k < 10) begin
            idle();
            k++;
        end
        chk("latency", 64'(k), 64'(STAGES));
        chk("res_42", mult_result_o, 64'd42);
        chk("tag_12", 64'(mult_dest_tag_o), 64'd12);
        chk("rob_3", 64'(mult_rob_idx_o), 64'd3);
        repeat (3) idle();

        // wrap and sign
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1, 4'b0000);
        issue(64'h1_0000_0000, 64'h1_0000_0000, 2, 2, 4'b0000);
        repeat (2) idle();
        chk("res_neg5", mult_result_o, 64'hFFFF_FFFF_FFFF_FFFB);
        idle();
        chk("res_wrap0", mult_result_o, 64'd0);
        chk("wrap_done", 64'(mult_done_o), 64'd1);
        repeat (3) idle();

        // back-to-back plus a non-mult issue
        done_cnt = 0;
        for (int i = 1; i <= 4; i++) issue(64'(i), 64'(i), 20 + i, i, 4'b0000);
        issue(64'd3, 64'd3, 30, 9, 4'b0000, FU_SEL_ALU);
        repeat (6) idle();
        chk("b2b_count", 64'(done_cnt), 64'd4);

        // recovery squashes only overlapping masks
        done_cnt = 0;
        issue(64'd2, 64'd3, 1, 1, 4'b0001);
        issue(64'd4, 64'd5, 2, 2, 4'b0010);
        issue(64'd6, 64'd7, 3, 3, 4'b0001);
        idle(0, 1, 4'b0001);
        repeat (6) idle();
        chk("rec_count", 64'(done_cnt), 64'd1);

        // correct prediction clears the mask bit
        issue(64'd9, 64'd9, 5, 5, 4'b0011);
        idle();
        idle(1, 0, 4'b0001);
        idle();
        chk("pc_done", 64'(mult_done_o), 64'd1);
        chk("pc_mask", 64'(mult_br_mask_o), 64'b0010);
        repeat (2) idle();

        // async reset mid-flight
        issue(64'd11, 64'd2, 1, 1, 4'b0000);
        issue(64'd12, 64'd2, 2, 2, 4'b0000);
        issue(64'd13, 64'd2, 3, 3, 4'b0000);
        #3 rst = 1;
        #1;
        chk("async_rst_done", 64'(mult_done_o), 64'd0);
        q.delete();
        cycle();
        rst = 0;
        done_cnt = 0;
        repeat (6) idle();
        chk("post_rst_count", 64'(done_cnt), 64'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            iss_vld_i      = ($urandom_range(0, 3) != 0);
            iss_fu_sel_i   = ($urandom_range(0, 4) == 0) ? FU_SEL_W'($urandom_range(0, 3)) : FU_SEL_MULT;
            iss_opa_i      = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            iss_opb_i      = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
            iss_dest_tag_i = PRF_IDX_W'($urandom);
            iss_rob_idx_i  = ROB_IDX_W'($urandom);
            iss_br_mask_i  = BR_MASK_W'($urandom);
            r = $urandom_range(0, 15);
            rob_br_pred_correct_i = (r < 3) || (r == 15);
            rob_br_recovery_i     = (r >= 3 && r < 5) || (r == 15);
            rob_br_tag_fix_i      = 4'b0001 << $urandom_range(0, 3);
            cycle();
        end
        idle();
        repeat (STAGES + 1) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
